// File: rtl/emesh_pkg.sv
// Shared definitions for the eMesh FIFO arbiter: packet layout, class encodings and helpers.
package emesh_pkg;

    // Packet layout {write, datamode[1:0], ctrlmode[3:0], dstaddr, srcaddr, data}, write at MSB
    localparam int PW           = 103;
    localparam int DATA_LSB     = 0;
    localparam int DATA_W       = 32;
    localparam int SRCADDR_LSB  = 32;
    localparam int SRCADDR_W    = 32;
    localparam int DSTADDR_LSB  = 64;
    localparam int DSTADDR_W    = 32;
    localparam int CTRLMODE_LSB = 96;
    localparam int CTRLMODE_W   = 4;
    localparam int DATAMODE_LSB = 100;
    localparam int DATAMODE_W   = 2;
    localparam int WRITE_BIT    = 102;

    // Transaction class of a packet; the values double as bit positions in grant vectors
    typedef enum logic [1:0] {
        CLS_WR = 2'd0,
        CLS_RQ = 2'd1,
        CLS_RR = 2'd2
    } cls_e;

    function automatic logic pkt_is_write(input logic [PW-1:0] pkt);
        return pkt[WRITE_BIT];
    endfunction

endpackage

// File: rtl/emesh_fifo_arbiter_if.sv
// Bundle of the three FWFT FIFO heads and the merged eMesh master port.
interface emesh_fifo_arbiter_if;
    import emesh_pkg::*;

    logic          emwr_empty;
    logic [PW-1:0] emwr_packet;
    logic          emwr_rd_en;
    logic          emrq_empty;
    logic [PW-1:0] emrq_packet;
    logic          emrq_rd_en;
    logic          emrr_empty;
    logic [PW-1:0] emrr_packet;
    logic          emrr_rd_en;
    logic          emesh_access;
    logic [PW-1:0] emesh_packet;
    logic          emesh_wr_wait;
    logic          emesh_rd_wait;

    // Arbiter side: pops the FIFOs and drives the merged port
    modport master (
        input  emwr_empty, emwr_packet,
        input  emrq_empty, emrq_packet,
        input  emrr_empty, emrr_packet,
        input  emesh_wr_wait, emesh_rd_wait,
        output emwr_rd_en, emrq_rd_en, emrr_rd_en,
        output emesh_access, emesh_packet
    );

    // Environment side: FIFOs and downstream consumer
    modport slave (
        output emwr_empty, emwr_packet,
        output emrq_empty, emrq_packet,
        output emrr_empty, emrr_packet,
        output emesh_wr_wait, emesh_rd_wait,
        input  emwr_rd_en, emrq_rd_en, emrr_rd_en,
        input  emesh_access, emesh_packet
    );

endinterface

// File: rtl/emesh_arb_grant.sv
// Combinational grant picker: read responses first (unless their burst is used up),
// then round-robin between writes and read requests. Output is one-hot or zero.
module emesh_arb_grant
    import emesh_pkg::*;
(
    input  logic [2:0] elig_i,
    input  cls_e       rr_ptr_i,
    input  logic       burst_at_max_i,
    output logic [2:0] grant_o
);

    logic other_pending;

    assign other_pending = elig_i[CLS_WR] | elig_i[CLS_RQ];

    // Pick one eligible class; a capped response burst yields only if someone else is waiting
    always_comb begin
        grant_o = 3'b000;
        if (elig_i[CLS_RR] && !(burst_at_max_i && other_pending)) begin
            grant_o[CLS_RR] = 1'b1;
        end else if (elig_i[CLS_WR] && elig_i[CLS_RQ]) begin
            if (rr_ptr_i == CLS_RQ) begin
                grant_o[CLS_RQ] = 1'b1;
            end else begin
                grant_o[CLS_WR] = 1'b1;
            end
        end else if (elig_i[CLS_WR]) begin
            grant_o[CLS_WR] = 1'b1;
        end else if (elig_i[CLS_RQ]) begin
            grant_o[CLS_RQ] = 1'b1;
        end
    end

endmodule

// File: rtl/emesh_fifo_arbiter.sv
// Merges the write, read-request and read-response FIFOs onto one registered eMesh port.
module emesh_fifo_arbiter
    import emesh_pkg::*;
#(
    parameter int MAX_BURST = 4
)
(
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 arb_en,
    emesh_fifo_arbiter_if.master bus
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic          access_q,    access_d;
    logic [PW-1:0] packet_q,    packet_d;
    cls_e          out_cls_q,   out_cls_d;
    cls_e          rr_ptr_q,    rr_ptr_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;

    logic       out_blocked;
    logic       done;
    logic       free;
    logic       burst_at_max;
    logic [2:0] elig;
    logic [2:0] grant_raw;
    logic [2:0] grant;

    // The held packet is stalled only by the wait line of its own class
    assign out_blocked = (out_cls_q == CLS_RQ) ? bus.emesh_rd_wait : bus.emesh_wr_wait;
    assign done        = access_q & ~out_blocked;
    assign free        = ~access_q | done;

    assign elig = {arb_en & ~bus.emrr_empty & ~bus.emesh_wr_wait,
                   arb_en & ~bus.emrq_empty & ~bus.emesh_rd_wait,
                   arb_en & ~bus.emwr_empty & ~bus.emesh_wr_wait};

    assign burst_at_max = (burst_cnt_q == BURST_LIMIT);

    emesh_arb_grant u_grant (
        .elig_i         (elig),
        .rr_ptr_i       (rr_ptr_q),
        .burst_at_max_i (burst_at_max),
        .grant_o        (grant_raw)
    );

    // Grants only land on a free port, and nothing is popped while in reset
    assign grant = (free && nreset) ? grant_raw : 3'b000;

    assign bus.emwr_rd_en   = grant[CLS_WR];
    assign bus.emrq_rd_en   = grant[CLS_RQ];
    assign bus.emrr_rd_en   = grant[CLS_RR];
    assign bus.emesh_access = access_q;
    assign bus.emesh_packet = packet_q;

    // Next-state: capture the granted head, retire a finished packet, steer pointer and burst count
    always_comb begin
        access_d    = access_q;
        packet_d    = packet_q;
        out_cls_d   = out_cls_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (grant[CLS_RR]) begin
            access_d  = 1'b1;
            packet_d  = bus.emrr_packet;
            out_cls_d = CLS_RR;
            if (burst_cnt_q < BURST_LIMIT) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end else if (grant[CLS_WR]) begin
            access_d    = 1'b1;
            packet_d    = bus.emwr_packet;
            out_cls_d   = CLS_WR;
            rr_ptr_d    = CLS_RQ;
            burst_cnt_d = 4'd0;
        end else if (grant[CLS_RQ]) begin
            access_d    = 1'b1;
            packet_d    = bus.emrq_packet;
            out_cls_d   = CLS_RQ;
            rr_ptr_d    = CLS_WR;
            burst_cnt_d = 4'd0;
        end else begin
            if (done) begin
                access_d = 1'b0;
            end
            if (!elig[CLS_WR] && !elig[CLS_RQ]) begin
                burst_cnt_d = 4'd0;
            end
        end
    end

    // State register with synchronous active-low reset; a held packet is dropped on reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            access_q    <= 1'b0;
            packet_q    <= '0;
            out_cls_q   <= CLS_WR;
            rr_ptr_q    <= CLS_WR;
            burst_cnt_q <= 4'd0;
        end else begin
            access_q    <= access_d;
            packet_q    <= packet_d;
            out_cls_q   <= out_cls_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
